smg_scan_driver: RTL

//  Display end of the 24-bit Number_Sig interface: accepts six packed BCD digits and drives a
//  6-digit common-anode seven-segment display by time-multiplexed scanning.

---
 rtl/smg_scan_driver.sv | 129 ++++++++++++
 1 files changed

// File: rtl/smg_scan_driver.sv
// smg_scan_driver
//   Drives a 6-digit common-anode seven-segment display by time-multiplexed
//   scanning. It takes six packed BCD digits from the number-producing logic.
//   At every frame boundary it captures a coherent snapshot of the digits and
//   of the blanking request. Each slot opens with a dead time in which all
//   digits are off, which suppresses ghosting between neighbouring digits.
//
// Parameters
//   T_SCAN      slot length minus 1, in CLK cycles (a slot is T_SCAN+1 cycles)
//   T_DEAD      cycles at the start of each slot with every digit disabled
//               (must satisfy 0 < T_DEAD < T_SCAN)
//
// Ports
//   CLK         system clock
//   RSTn        asynchronous reset, active-low
//   Number_Sig  six BCD digits: [3:0] = digit 0 (ones) ... [23:20] = digit 5
//   Blank_En    1 = blank leading zeros
//   SMG_Data    segments, active-low, bit order {dp,g,f,e,d,c,b,a}; dp is always off
//   Scan_Sig    digit enables, active-low; bit k selects digit k
//   Frame_Done  one-cycle pulse at the end of each 6-slot frame
module smg_scan_driver #(
  parameter logic [15:0] T_SCAN = 16'd49_999,
  parameter logic [15:0] T_DEAD = 16'd499
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [23:0] Number_Sig,
  input  logic        Blank_En,
  output logic [7:0]  SMG_Data,
  output logic [5:0]  Scan_Sig,
  output logic        Frame_Done
);

  logic [15:0] c1_reg;
  logic [2:0]  idx_reg;
  logic [23:0] snap_reg;
  logic        blank_snap_reg;

  logic        slot_end;
  logic        frame_end;
  logic [5:0]  zero_from;     // zero_from[k]: snapshot nibbles k..5 are all zero
  logic [3:0]  nib_sel;
  logic        blank_sel;
  logic        idx_valid;
  logic [7:0]  smg_next;
  logic [5:0]  scan_next;

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 8'hC0;
      4'd1:    seg_decode = 8'hF9;
      4'd2:    seg_decode = 8'hA4;
      4'd3:    seg_decode = 8'hB0;
      4'd4:    seg_decode = 8'h99;
      4'd5:    seg_decode = 8'h92;
      4'd6:    seg_decode = 8'h82;
      4'd7:    seg_decode = 8'hF8;
      4'd8:    seg_decode = 8'h80;
      4'd9:    seg_decode = 8'h90;
      default: seg_decode = 8'hBF;  // non-BCD nibble shows "-"
    endcase
  endfunction

  // Each digit k looks at its own nibble and every more significant nibble.
  // Any non-zero nibble, including the non-BCD codes, stops blanking.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_zero
      assign zero_from[gi] = (snap_reg[23:4*gi] == '0);
    end
  endgenerate

  assign slot_end  = (c1_reg == T_SCAN);
  assign frame_end = slot_end && (idx_reg == 3'd5);

  always_comb begin
    nib_sel   = 4'd0;
    blank_sel = 1'b0;
    idx_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (idx_reg == k[2:0]) begin
        nib_sel   = snap_reg[4*k +: 4];
        blank_sel = (k != 0) && blank_snap_reg && zero_from[k];
        idx_valid = 1'b1;
      end
    end
  end

  // Index values 6 and 7 cannot be reached; they decode to "all off".
  always_comb begin
    smg_next  = 8'hFF;
    scan_next = 6'h3F;
    if (idx_valid) begin
      if (!blank_sel) begin
        smg_next = seg_decode(nib_sel);
      end
      if (c1_reg >= T_DEAD) begin
        scan_next = ~(6'd1 << idx_reg);
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      c1_reg         <= 16'd0;
      idx_reg        <= 3'd0;
      snap_reg       <= 24'h0;
      blank_snap_reg <= 1'b0;
      SMG_Data       <= 8'hFF;
      Scan_Sig       <= 6'h3F;
      Frame_Done     <= 1'b0;
    end else begin
      SMG_Data   <= smg_next;
      Scan_Sig   <= scan_next;
      Frame_Done <= frame_end;
      if (slot_end) begin
        c1_reg  <= 16'd0;
        idx_reg <= (idx_reg == 3'd5) ? 3'd0 : idx_reg + 3'd1;
      end else begin
        c1_reg <= c1_reg + 16'd1;
      end
      // The new snapshot becomes visible from slot 0 of the next frame.
      if (frame_end) begin
        snap_reg       <= Number_Sig;
        blank_snap_reg <= Blank_En;
      end
    end
  end

endmodule
